// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encodings, halt opcode and field widths.
// Imported by fetch_seq_ctrl and sat_counter.
package fetch_seq_ctrl_pkg;

  localparam int NB_STATE  = 3;
  localparam int NB_OPCODE = 6;

  localparam logic [NB_OPCODE-1:0] FSC_HALT_OPCODE = 6'h3F;

  typedef enum logic [NB_STATE-1:0] {
    FSC_IDLE   = 3'd0,
    FSC_RUN    = 3'd1,
    FSC_STEP   = 3'd2,
    FSC_DRAIN  = 3'd3,
    FSC_HALTED = 3'd4
  } fsc_state_e;

  // True when the opcode field of an instruction marks the end of the program.
  function automatic logic is_halt_opcode(input logic [NB_OPCODE-1:0] opcode,
                                          input logic [NB_OPCODE-1:0] halt_opcode);
    return (opcode == halt_opcode);
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
// Used by fetch_seq_ctrl for the pipeline-active cycle count.
module sat_counter
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [NB-1:0] o_cnt
);

  logic [NB-1:0] cnt_q;
  logic [NB-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en && (cnt_q != {NB{1'b1}})) begin
      cnt_d = cnt_q + NB'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: run/step/halt control, stall and branch-flush handling, halt drain.
// Optional macro FETCH_CYCLE_CNT_EN enables the saturating pipeline-active cycle counter.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int                    NB_BITS      = 32,
  parameter int                    NB_CNT       = 32,
  parameter int                    DRAIN_CYCLES = 4,
  parameter logic [NB_OPCODE-1:0]  HALT_OPCODE  = FSC_HALT_OPCODE
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_du_run,
  input  logic                i_du_step,
  input  logic                i_du_halt,
  input  logic                i_hz_stall,
  input  logic                i_ctr_beq,
  input  logic                i_ctr_jmp,
  input  logic [NB_BITS-1:0]  i_if_id_instr,
  output logic                o_pc_we,
  output logic                o_if_id_we,
  output logic                o_ctr_flush,
  output logic                o_pipe_en,
  output logic [NB_STATE-1:0] o_state,
  output logic                o_done,
  output logic [NB_CNT-1:0]   o_cycle_cnt
);

  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

  fsc_state_e          state_q;
  fsc_state_e          state_d;
  logic [NB_DRAIN-1:0] drain_q;
  logic [NB_DRAIN-1:0] drain_d;
  logic                halt_hit;
  logic                branch_req;
  logic                unused_instr_bits;

  assign halt_hit   = is_halt_opcode(i_if_id_instr[NB_BITS-1 -: NB_OPCODE], HALT_OPCODE) | i_du_halt;
  assign branch_req = i_ctr_beq | i_ctr_jmp;

  // Only the opcode field matters to the sequencer.
  assign unused_instr_bits = ^i_if_id_instr[NB_BITS-NB_OPCODE-1:0];

  always_comb begin
    state_d     = state_q;
    drain_d     = '0;
    o_pc_we     = 1'b0;
    o_if_id_we  = 1'b0;
    o_ctr_flush = 1'b0;
    o_pipe_en   = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      FSC_IDLE: begin
        if (i_du_run) begin
          state_d = FSC_RUN;
        end else if (i_du_step) begin
          state_d = FSC_STEP;
        end
      end

      FSC_RUN, FSC_STEP: begin
        // A stalled branch is held back; the hazard unit re-presents it next cycle.
        o_pipe_en   = 1'b1;
        o_if_id_we  = ~i_hz_stall;
        o_ctr_flush = branch_req & ~i_hz_stall;
        o_pc_we     = ~i_hz_stall & ~halt_hit;
        if (halt_hit) begin
          state_d = FSC_DRAIN;
        end else if ((state_q == FSC_STEP) && !i_hz_stall) begin
          state_d = FSC_IDLE;
        end
      end

      FSC_DRAIN: begin
        o_pipe_en   = 1'b1;
        o_if_id_we  = 1'b1;
        o_ctr_flush = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = FSC_HALTED;
        end else begin
          drain_d = drain_q + NB_DRAIN'(1);
        end
      end

      FSC_HALTED: begin
        o_done = 1'b1;
      end

      default: begin
        state_d = FSC_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= FSC_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign o_state = state_q;

`ifdef FETCH_CYCLE_CNT_EN
  sat_counter #(
    .NB (NB_CNT)
  ) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_pipe_en),
    .o_cnt (o_cycle_cnt)
  );
`else
  assign o_cycle_cnt = '0;
`endif

endmodule
